// File: rtl/vram_scanout.sv
// Display-side VRAM scanout: walks a latched rectangular 16bpp region, converts
// BGR555 to RGB888 and buffers pixels in a FIFO drained over valid/ready.
module vram_scanout #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic        clk_53_2MHz,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        abort,
  input  logic [9:0]  disp_x,
  input  logic [8:0]  disp_y,
  input  logic [9:0]  disp_w,
  input  logic [8:0]  disp_h,
  output logic        vram_req,
  input  logic        vram_gnt,
  output logic [8:0]  vram_line,
  output logic [11:0] vram_col,
  output logic [3:0]  vram_mode,
  output logic        vram_re,
  input  logic [23:0] vram_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    FETCH
  } state_e;

  typedef struct packed {
    logic [23:0] rgb;
    logic        eol;
    logic        eof;
  } pix_t;

  state_e           state_q, state_d;
  logic [9:0]       x0_q, x0_d;
  logic [8:0]       y0_q, y0_d;
  logic [9:0]       w_q, w_d;
  logic [8:0]       h_q, h_d;
  logic [9:0]       x_cnt_q, x_cnt_d;
  logic [8:0]       y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  pix_t             mem_q [FIFO_DEPTH];
  pix_t             mem_d [FIFO_DEPTH];

  logic [4:0] r5, g5, b5;
  logic       eol, eof, push, pop;
  pix_t       new_pix;
  logic [8:0] unused_rdata;

  assign unused_rdata = vram_rdata[23:15];

  always_comb begin
    vram_req  = (state_q == FETCH) && (count_q != FULL);
    vram_re   = vram_req && vram_gnt;
    vram_line = y0_q + y_cnt_q;
    vram_col  = {2'b00, x0_q + x_cnt_q};
    vram_mode = 4'd2;
    busy      = (state_q == FETCH);

    pix_valid = (count_q != '0);
    pix_data  = mem_q[rd_ptr_q].rgb;
    pix_eol   = mem_q[rd_ptr_q].eol;
    pix_eof   = mem_q[rd_ptr_q].eof;

    r5 = vram_rdata[4:0];
    g5 = vram_rdata[9:5];
    b5 = vram_rdata[14:10];
    eol = (x_cnt_q == w_q - 10'd1);
    eof = eol && (y_cnt_q == h_q - 9'd1);
    new_pix.rgb = {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
    new_pix.eol = eol;
    new_pix.eof = eof;

    push = vram_re;
    pop  = pix_valid && pix_ready;
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    // abort overrides geometry latch, push and pop in the same cycle
    if (abort) begin
      state_d  = IDLE;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start && (disp_w != '0) && (disp_h != '0)) begin
            state_d = FETCH;
            x0_d    = disp_x;
            y0_d    = disp_y;
            w_d     = disp_w;
            h_d     = disp_h;
            x_cnt_d = '0;
            y_cnt_d = '0;
          end
        end
        FETCH: begin
          if (push && eof) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (push) begin
        mem_d[wr_ptr_q] = new_pix;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        if (eol) begin
          x_cnt_d = '0;
          y_cnt_d = y_cnt_q + 9'd1;
        end else begin
          x_cnt_d = x_cnt_q + 10'd1;
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_53_2MHz or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout: table of frames plus hand sequences for
// backpressure, abort and mid-frame reset; a scoreboard tracks expected pixels.
`timescale 1ns/1ps
module tb_vram_scanout;

  localparam int FIFO_DEPTH = 16;

  logic        clk_53_2MHz = 1'b0;
  logic        rst;
  logic        frame_start, abort;
  logic [9:0]  disp_x, disp_w;
  logic [8:0]  disp_y, disp_h;
  logic        vram_req, vram_gnt, vram_re;
  logic [8:0]  vram_line;
  logic [11:0] vram_col;
  logic [3:0]  vram_mode;
  logic [23:0] vram_rdata;
  logic        pix_valid, pix_ready, pix_eol, pix_eof, busy;
  logic [23:0] pix_data;

  logic        use_fixed;
  logic [15:0] fixed;

  vram_scanout #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
    .clk_53_2MHz(clk_53_2MHz), .rst(rst), .frame_start(frame_start), .abort(abort),
    .disp_x(disp_x), .disp_y(disp_y), .disp_w(disp_w), .disp_h(disp_h),
    .vram_req(vram_req), .vram_gnt(vram_gnt), .vram_line(vram_line), .vram_col(vram_col),
    .vram_mode(vram_mode), .vram_re(vram_re), .vram_rdata(vram_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
  );

  always #5 clk_53_2MHz = ~clk_53_2MHz;

  function automatic logic [15:0] memf(input logic [8:0] l, input logic [11:0] c);
    logic [15:0] a, b;
    a = {7'b0, l};
    b = {4'b0, c};
    return (a * 16'd37) ^ (b * 16'd101) ^ 16'hA5C3;
  endfunction

  function automatic logic [23:0] pixf(input logic [15:0] d);
    logic [7:0] r, g, b;
    r = {3'b0, d[4:0]};
    g = {3'b0, d[9:5]};
    b = {3'b0, d[14:10]};
    r = (r << 3) | (r >> 2);
    g = (g << 3) | (g >> 2);
    b = (b << 3) | (b >> 2);
    return {r, g, b};
  endfunction

  assign vram_rdata = use_fixed ? {8'hEE, fixed} : {8'h5A, memf(vram_line, vram_col)};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // reference model state
  logic [25:0] q[$];
  logic        mbusy = 1'b0;
  logic [9:0]  gx, gw, mx;
  logic [8:0]  gy, gh, my;
  int          rd_cnt = 0;
  int          pop_cnt = 0;
  logic [23:0] last_pix = '0;

  always @(negedge clk_53_2MHz) begin
    logic        busy_now, e_eol, e_eof;
    logic [8:0]  e_line;
    logic [11:0] e_col;
    logic [25:0] e;
    if (!rst) begin
      busy_now = mbusy;
      chk("busy", busy, busy_now);
      chk("vram_req", vram_req, busy_now && (q.size() < FIFO_DEPTH));
      chk("vram_re", vram_re, vram_req && vram_gnt);
      chk("pix_valid", pix_valid, q.size() != 0);
      chk("vram_mode", vram_mode, 4'd2);
      if (vram_re) begin
        e_line = gy + my;
        e_col  = {2'b00, 10'(gx + mx)};
        e_eol  = ({1'b0, mx} + 11'd1 == {1'b0, gw});
        e_eof  = e_eol && ({1'b0, my} + 10'd1 == {1'b0, gh});
        chk("read_while_idle", busy_now, 1'b1);
        chk("vram_line", vram_line, e_line);
        chk("vram_col", vram_col, e_col);
        e = {pixf(use_fixed ? fixed : memf(e_line, e_col)), e_eol, e_eof};
        rd_cnt++;
        if (!abort) begin
          q.push_back(e);
          if (e_eol) begin mx = '0; my = my + 9'd1; end
          else mx = mx + 10'd1;
          if (e_eof) mbusy = 1'b0;
        end
      end
      if (pix_valid && pix_ready) begin
        if (q.size() == 0) begin
          chk("pop_empty", pix_valid, 1'b0);
        end else begin
          chk("pix_data", pix_data, q[0][25:2]);
          chk("pix_eol", pix_eol, q[0][1]);
          chk("pix_eof", pix_eof, q[0][0]);
          if (!abort) void'(q.pop_front());
        end
        pop_cnt++;
        last_pix = pix_data;
      end
      if (abort) begin
        q.delete();
        mbusy = 1'b0;
      end else if (frame_start && !busy_now && disp_w != '0 && disp_h != '0) begin
        gx = disp_x; gy = disp_y; gw = disp_w; gh = disp_h;
        mx = '0; my = '0;
        mbusy = 1'b1;
      end
    end
  end

  typedef struct {
    int          x, y, w, h;
    bit          gtog;
    bit          use_fixed;
    logic [15:0] fixed;
    logic [23:0] exp_pix;
    int          exp_reads;
  } vec_t;

  vec_t vecs[7];

  task automatic pulse_start(input int x, input int y, input int w, input int h);
    disp_x = 10'(x); disp_y = 9'(y); disp_w = 10'(w); disp_h = 9'(h);
    frame_start = 1'b1;
    @(posedge clk_53_2MHz); #1;
    frame_start = 1'b0;
    // scramble the inputs to show the geometry was latched
    disp_x = 10'h3AB; disp_y = 9'h0C5; disp_w = 10'd3; disp_h = 9'd2;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk_53_2MHz); #1;
      if (c >= 3 && !busy && !pix_valid) begin done = 1'b1; break; end
    end
    if (!done) fail_now(nm);
  endtask

  task automatic run_vec(input vec_t v);
    bit done = 1'b0;
    vram_gnt  = v.gtog ? 1'b0 : 1'b1;
    pix_ready = 1'b1;
    use_fixed = v.use_fixed;
    fixed     = v.fixed;
    rd_cnt    = 0;
    pulse_start(v.x, v.y, v.w, v.h);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_53_2MHz); #1;
      if (v.gtog) vram_gnt = ~vram_gnt;
      frame_start = (c == 2 && v.exp_reads >= 8);
      if (c >= 4 && !busy && !pix_valid) begin done = 1'b1; break; end
    end
    frame_start = 1'b0;
    if (!done) fail_now("frame_timeout");
    chk("read_count", rd_cnt, v.exp_reads);
    if (v.use_fixed) chk("colour", last_pix, v.exp_pix);
  endtask

  initial begin
    vecs[0] = '{x:10,   y:20,  w:4,  h:2, gtog:0, use_fixed:0, fixed:16'h0,    exp_pix:24'h0,      exp_reads:8};
    vecs[1] = '{x:1022, y:511, w:4,  h:2, gtog:1, use_fixed:0, fixed:16'h0,    exp_pix:24'h0,      exp_reads:8};
    vecs[2] = '{x:0,    y:0,   w:1,  h:1, gtog:0, use_fixed:1, fixed:16'h7C1F, exp_pix:24'hFF00FF, exp_reads:1};
    vecs[3] = '{x:5,    y:5,   w:1,  h:1, gtog:0, use_fixed:1, fixed:16'h0421, exp_pix:24'h080808, exp_reads:1};
    vecs[4] = '{x:100,  y:3,   w:0,  h:5, gtog:0, use_fixed:0, fixed:16'h0,    exp_pix:24'h0,      exp_reads:0};
    vecs[5] = '{x:3,    y:7,   w:6,  h:0, gtog:0, use_fixed:0, fixed:16'h0,    exp_pix:24'h0,      exp_reads:0};
    vecs[6] = '{x:700,  y:100, w:17, h:3, gtog:0, use_fixed:0, fixed:16'h0,    exp_pix:24'h0,      exp_reads:51};

    rst = 1'b1; frame_start = 1'b0; abort = 1'b0;
    disp_x = '0; disp_y = '0; disp_w = '0; disp_h = '0;
    vram_gnt = 1'b0; pix_ready = 1'b0; use_fixed = 1'b0; fixed = '0;
    repeat (3) @(posedge clk_53_2MHz);
    #1;
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vram_req", vram_req, 1'b0);
    chk("rst_vram_re", vram_re, 1'b0);
    chk("rst_vram_mode", vram_mode, 4'd2);
    chk("rst_pix_data", pix_data, 24'h0);
    chk("rst_addr", {vram_line, vram_col}, 21'h0);
    chk("rst_eol_eof", {pix_eol, pix_eof}, 2'b00);
    rst = 1'b0;
    @(posedge clk_53_2MHz); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // backpressure: FIFO fills to depth, request drops, then drains in order
    vram_gnt = 1'b1; pix_ready = 1'b0; use_fixed = 1'b0; rd_cnt = 0; pop_cnt = 0;
    pulse_start(50, 60, 40, 1);
    repeat (40) @(posedge clk_53_2MHz);
    #1;
    chk("bp_reads", rd_cnt, 16);
    chk("bp_req_low", vram_req, 1'b0);
    chk("bp_busy", busy, 1'b1);
    pix_ready = 1'b1;
    wait_done("bp_timeout", 500);
    chk("bp_total_reads", rd_cnt, 40);
    chk("bp_total_pops", pop_cnt, 40);

    // abort mid-frame, with a coincident frame_start that must lose
    pix_ready = 1'b0; rd_cnt = 0;
    pulse_start(200, 30, 8, 4);
    repeat (5) @(posedge clk_53_2MHz);
    #1;
    abort = 1'b1; frame_start = 1'b1; disp_w = 10'd5; disp_h = 9'd5;
    @(posedge clk_53_2MHz); #1;
    abort = 1'b0; frame_start = 1'b0;
    chk("abort_valid", pix_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_req", vram_req, 1'b0);
    pix_ready = 1'b1; rd_cnt = 0;
    pulse_start(0, 0, 3, 1);
    wait_done("post_abort_timeout", 200);
    chk("post_abort_reads", rd_cnt, 3);

    // asynchronous reset with pixels buffered
    begin
      bit hit = 1'b0;
      pix_ready = 1'b0; rd_cnt = 0;
      pulse_start(0, 0, 20, 2);
      for (int c = 0; c < 100; c++) begin
        if (rd_cnt == 5) begin hit = 1'b1; break; end
        @(posedge clk_53_2MHz); #1;
      end
      if (!hit) fail_now("reset_setup_timeout");
      #2;
      rst = 1'b1;
      q.delete();
      mbusy = 1'b0;
      #1;
      chk("mid_rst_pix_valid", pix_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_req", vram_req, 1'b0);
      chk("mid_rst_mode", vram_mode, 4'd2);
      chk("mid_rst_pix_data", pix_data, 24'h0);
      repeat (2) @(posedge clk_53_2MHz);
      #1;
      rst = 1'b0;
      @(posedge clk_53_2MHz); #1;
    end

    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
